morse_letter_decoder: RTL and testbench

//  Consumes the 3-bit symbol stream produced by the dit/dah counter stage.

---
 rtl/morse_letter_decoder.sv | 169 ++++++++++++++++
 tb/tb_morse_letter_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_decoder.sv
// rtl/morse_letter_decoder.sv - assembles dit/dah symbols into letters and emits ASCII over valid/ready
module morse_letter_decoder #(
    parameter int MAX_SYMS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ditsdahs,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       sym_error,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, COLLECT, DISCARD, EMIT_CH, EMIT_SP} state_t;

    state_t              state, state_d;
    logic [MAX_SYMS-1:0] pattern, pattern_d;
    logic [2:0]          count, count_d;
    logic                pend_sp, pend_sp_d;
    logic                space_armed, space_armed_d;
    logic                ovf, ovf_d;
    logic                load, load_err, drop;
    logic [7:0]          load_val, lut_char;

    logic is_dit, is_dah, is_sym, is_lgap, is_wgap, can_load;

    assign is_dit   = (ditsdahs == 3'b001);
    assign is_dah   = (ditsdahs == 3'b010);
    assign is_sym   = is_dit | is_dah;
    assign is_lgap  = (ditsdahs == 3'b011);
    assign is_wgap  = (ditsdahs == 3'b100);
    assign can_load = !char_valid || char_ready;

    // 8'h00 marks a key with no table entry
    function automatic logic [7:0] lut(input logic [2:0] n, input logic [5:0] p);
        case ({n, p})
            {3'd2, 6'b000001}: lut = 8'h41;  {3'd4, 6'b001000}: lut = 8'h42;
            {3'd4, 6'b001010}: lut = 8'h43;  {3'd3, 6'b000100}: lut = 8'h44;
            {3'd1, 6'b000000}: lut = 8'h45;  {3'd4, 6'b000010}: lut = 8'h46;
            {3'd3, 6'b000110}: lut = 8'h47;  {3'd4, 6'b000000}: lut = 8'h48;
            {3'd2, 6'b000000}: lut = 8'h49;  {3'd4, 6'b000111}: lut = 8'h4A;
            {3'd3, 6'b000101}: lut = 8'h4B;  {3'd4, 6'b000100}: lut = 8'h4C;
            {3'd2, 6'b000011}: lut = 8'h4D;  {3'd2, 6'b000010}: lut = 8'h4E;
            {3'd3, 6'b000111}: lut = 8'h4F;  {3'd4, 6'b000110}: lut = 8'h50;
            {3'd4, 6'b001101}: lut = 8'h51;  {3'd3, 6'b000010}: lut = 8'h52;
            {3'd3, 6'b000000}: lut = 8'h53;  {3'd1, 6'b000001}: lut = 8'h54;
            {3'd3, 6'b000001}: lut = 8'h55;  {3'd4, 6'b000001}: lut = 8'h56;
            {3'd3, 6'b000011}: lut = 8'h57;  {3'd4, 6'b001001}: lut = 8'h58;
            {3'd4, 6'b001011}: lut = 8'h59;  {3'd4, 6'b001100}: lut = 8'h5A;
            {3'd5, 6'b011111}: lut = 8'h30;  {3'd5, 6'b001111}: lut = 8'h31;
            {3'd5, 6'b000111}: lut = 8'h32;  {3'd5, 6'b000011}: lut = 8'h33;
            {3'd5, 6'b000001}: lut = 8'h34;  {3'd5, 6'b000000}: lut = 8'h35;
            {3'd5, 6'b010000}: lut = 8'h36;  {3'd5, 6'b011000}: lut = 8'h37;
            {3'd5, 6'b011100}: lut = 8'h38;  {3'd5, 6'b011110}: lut = 8'h39;
            default:           lut = 8'h00;
        endcase
    endfunction

    assign lut_char = lut(count, 6'(pattern));

    always_comb begin
        state_d       = state;
        pattern_d     = pattern;
        count_d       = count;
        pend_sp_d     = pend_sp;
        space_armed_d = space_armed;
        ovf_d         = ovf;
        load          = 1'b0;
        load_val      = 8'h00;
        load_err      = 1'b0;
        drop          = 1'b0;
        case (state)
            IDLE: begin
                if (is_sym) begin
                    pattern_d = {{(MAX_SYMS-1){1'b0}}, is_dah};
                    count_d   = 3'd1;
                    state_d   = COLLECT;
                end else if (is_wgap && space_armed) begin
                    state_d = EMIT_SP;
                end
            end
            COLLECT: begin
                if (is_sym) begin
                    if (count == 3'(MAX_SYMS)) begin
                        ovf_d   = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        pattern_d = {pattern[MAX_SYMS-2:0], is_dah};
                        count_d   = count + 3'd1;
                    end
                end else if (is_lgap || is_wgap) begin
                    pend_sp_d = is_wgap;
                    state_d   = EMIT_CH;
                end
            end
            DISCARD: begin
                if (is_lgap || is_wgap) begin
                    pend_sp_d = is_wgap;
                    state_d   = EMIT_CH;
                end
            end
            EMIT_CH: begin
                if (can_load) begin
                    load          = 1'b1;
                    load_err      = ovf || (lut_char == 8'h00);
                    load_val      = load_err ? 8'h3F : lut_char;
                    space_armed_d = 1'b1;
                    state_d       = pend_sp ? EMIT_SP : IDLE;
                    pattern_d     = '0;
                    count_d       = 3'd0;
                    pend_sp_d     = 1'b0;
                    ovf_d         = 1'b0;
                end else begin
                    drop = is_sym || is_lgap || is_wgap;
                end
            end
            EMIT_SP: begin
                if (can_load) begin
                    load          = 1'b1;
                    load_val      = 8'h20;
                    space_armed_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    drop = is_sym || is_lgap || is_wgap;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pattern     <= '0;
            count       <= 3'd0;
            pend_sp     <= 1'b0;
            space_armed <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state       <= state_d;
            pattern     <= pattern_d;
            count       <= count_d;
            pend_sp     <= pend_sp_d;
            space_armed <= space_armed_d;
            ovf         <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            sym_error  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= overrun | drop;
            if (load) begin
                char_out   <= load_val;
                char_valid <= 1'b1;
                sym_error  <= load_err;
            end else begin
                sym_error <= 1'b0;
                if (char_ready) char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// tb/tb_morse_letter_decoder.sv - directed and random checks of morse_letter_decoder against a string-level Morse model
module tb_morse_letter_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ditsdahs;
    logic [7:0] char_out;
    logic       char_valid;
    logic       ready;
    logic       sym_error;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    morse_letter_decoder #(.MAX_SYMS(6)) dut (
        .clk(clk), .reset(reset), .ditsdahs(ditsdahs), .char_out(char_out),
        .char_valid(char_valid), .char_ready(ready), .sym_error(sym_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};

    // Model: letter text so far, whether a space may follow, expected output stream
    string       cur = "";
    bit          armed = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          exp_errs = 0;
    int          seen_errs = 0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_char = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lookup(input string s);
        for (int i = 0; i < 36; i++)
            if (codes[i] == s) return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        return 8'h3F;
    endfunction

    task automatic emit_letter();
        logic [7:0] c;
        c = lookup(cur);
        exp_q.push_back(c);
        if (c == 8'h3F) exp_errs++;
        armed = 1'b1;
        cur = "";
    endtask

    task automatic model_apply(input logic [2:0] code);
        case (code)
            3'b001: cur = {cur, "."};
            3'b010: cur = {cur, "-"};
            3'b011: if (cur.len() > 0) emit_letter();
            3'b100: begin
                if (cur.len() > 0) emit_letter();
                if (armed) begin
                    exp_q.push_back(8'h20);
                    armed = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        cur = "";
        armed = 1'b0;
        exp_q.delete();
        got_q.delete();
        exp_errs = 0;
        seen_errs = 0;
    endtask

    task automatic pulse(input logic [2:0] code);
        @(posedge clk); #1 ditsdahs = code;
        @(posedge clk); #1 ditsdahs = 3'b000;
    endtask

    task automatic sym(input logic [2:0] code);
        model_apply(code);
        pulse(code);
        if (code == 3'b011 || code == 3'b100) repeat (2) @(posedge clk);
    endtask

    task automatic letter(input string s, input logic [2:0] gap);
        for (int i = 0; i < s.len(); i++) sym(s[i] == "-" ? 3'b010 : 3'b001);
        sym(gap);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_got(input string name, input logic [7:0] a, input logic [7:0] b, input int n);
        check({name, "_count"}, got_q.size(), n);
        if (n >= 1 && got_q.size() >= 1) check({name, "_c0"}, got_q[0], a);
        if (n >= 2 && got_q.size() >= 2) check({name, "_c1"}, got_q[1], b);
        got_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", char_valid, 1'b1);
                check("hold_stable", char_out, prev_char);
            end
            if (char_valid && ready) begin
                got_q.push_back(char_out);
                if (exp_q.size() == 0) check("unexpected_char", char_out, 8'hxx);
                else check("char", char_out, exp_q.pop_front());
            end
            if (sym_error) begin
                seen_errs++;
                check("sym_error_char", char_out, 8'h3F);
            end
            prev_hold = char_valid && !ready;
            prev_char = char_out;
        end
    end

    initial begin
        ditsdahs = 3'b000;
        ready = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_char", char_out, 8'h00);
        check("rst_valid", char_valid, 1'b0);
        check("rst_err", sym_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        #20 reset = 1'b0;

        check("model_A", lookup(".-"), 8'h41);
        check("model_B", lookup("-..."), 8'h42);
        check("model_0", lookup("-----"), 8'h30);
        check("model_bad", lookup("----"), 8'h3F);

        // Test 1: latency of a letter gap with widely spaced pulses
        model_apply(3'b001); pulse(3'b001); repeat (65) @(posedge clk);
        model_apply(3'b010); pulse(3'b010); repeat (65) @(posedge clk);
        model_apply(3'b011); pulse(3'b011);
        @(negedge clk); check("t1_n1_valid", char_valid, 1'b0);
        @(negedge clk); check("t1_n2_valid", char_valid, 1'b1);
        check("t1_char", char_out, 8'h41);
        check("t1_err", sym_error, 1'b0);
        @(negedge clk); check("t1_n3_valid", char_valid, 1'b0);
        drain(20); got_q.delete();

        // Test 2: B then 0
        letter("-...", 3'b011);
        letter("-----", 3'b011);
        drain(20); check_got("t2", 8'h42, 8'h30, 2);

        // Test 3: S, word gap, then a word gap with nothing armed
        letter("...", 3'b100);
        drain(20); check_got("t3", 8'h53, 8'h20, 2);
        sym(3'b100);
        drain(20); check_got("t3_nospace", 8'h00, 8'h00, 0);

        // Test 4: overflow and unmatched letters
        letter(".......", 3'b011);
        drain(20); check_got("t4_ovf", 8'h3F, 8'h00, 1);
        letter("----", 3'b011);
        drain(20); check_got("t4_nomatch", 8'h3F, 8'h00, 1);
        check("t4_err_count", seen_errs, exp_errs);

        // Random letters, idle codes and gaps with the output always ready
        for (int n = 0; n < 150; n++) begin
            int len;
            string s;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 8) : $urandom_range(1, 5);
            s = "";
            for (int i = 0; i < len; i++) begin
                s = {s, ($urandom_range(0, 1) == 1) ? "-" : "."};
            end
            for (int i = 0; i < s.len(); i++) begin
                if ($urandom_range(0, 7) == 0) sym(3'($urandom_range(5, 7)));
                sym(s[i] == "-" ? 3'b010 : 3'b001);
            end
            sym(($urandom_range(0, 2) == 0) ? 3'b100 : 3'b011);
            if ($urandom_range(0, 5) == 0) sym(3'b100);
            if ($urandom_range(0, 5) == 0) sym(3'b011);
        end
        drain(50);
        check("rand_err_count", seen_errs, exp_errs);
        check("rand_no_overrun", overrun, 1'b0);
        got_q.delete();

        // Test 5: stalled output, dropped symbol sets overrun
        ready = 1'b0;
        letter(".-", 3'b011);
        repeat (3) @(negedge clk);
        check("t5_held_valid", char_valid, 1'b1);
        check("t5_held_char", char_out, 8'h41);
        letter("...", 3'b011);
        pulse(3'b001);
        @(negedge clk);
        check("t5_overrun", overrun, 1'b1);
        check("t5_still_A", char_out, 8'h41);
        @(posedge clk); #1 ready = 1'b1;
        drain(20); check_got("t5", 8'h41, 8'h53, 2);
        check("t5_overrun_sticky", overrun, 1'b1);

        // Test 6: reset mid-letter
        sym(3'b010); sym(3'b010);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("t6_rst_char", char_out, 8'h00);
        check("t6_rst_valid", char_valid, 1'b0);
        check("t6_rst_ovr", overrun, 1'b0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        letter(".", 3'b011);
        drain(20); check_got("t6", 8'h45, 8'h00, 1);
        check("final_err_count", seen_errs, exp_errs);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
